mic_peak_level: RTL and testbench

MIC_PEAK_LEVEL -- requirements
Module: mic_peak_level

---
 rtl/vol_pkg.sv | 26 ++
 rtl/mic_abs_mag.sv | 17 +
 rtl/mic_peak_level.sv | 91 +++++++++
 tb/tb_mic_peak_level.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/vol_pkg.sv
// Constants and helpers shared by the mic peak meter and the volume bar display stage.
package vol_pkg;

    localparam logic [11:0] MIC_MID   = 12'd2048;
    localparam logic [10:0] LEVEL_MAX = 11'd2047;

    localparam logic [10:0] BAR_THRESH [9] = '{
        11'd205, 11'd409, 11'd614, 11'd819, 11'd1024,
        11'd1229, 11'd1434, 11'd1638, 11'd1842
    };

    typedef enum logic {
        ACCUM   = 1'b0,
        PUBLISH = 1'b1
    } peak_state_t;

    function automatic logic [3:0] bar_count(input logic [10:0] level);
        logic [3:0] bars;
        bars = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (BAR_THRESH[i] <= level) bars = bars + 4'd1;
        end
        return bars;
    endfunction

endpackage

// File: rtl/mic_abs_mag.sv
// Distance of an unsigned 12-bit mic sample from mid-scale, clipped to the 11-bit level range.
module mic_abs_mag
    import vol_pkg::*;
(
    input  logic [11:0] mic_in,
    output logic [10:0] mag
);

    logic [11:0] diff;

    always_comb begin
        diff = (mic_in >= MIC_MID) ? (mic_in - MIC_MID) : (MIC_MID - mic_in);
        // Only mic_in == 0 reaches 2048, the one value that needs clipping.
        mag  = diff[11] ? LEVEL_MAX : diff[10:0];
    end

endmodule

// File: rtl/mic_peak_level.sv
// Windowed peak detector for the mic volume bar; define MIC_PEAK_DECAY_EN for a falling peak-hold.
//   state   | meaning
//   ACCUM   | collecting the running peak of the current window
//   PUBLISH | one cycle after a window ends; num/level_idx just updated, num_valid high
module mic_peak_level
    import vol_pkg::*;
#(
    parameter int WINDOW     = 4000,
    parameter int DECAY_STEP = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_tick,
    input  logic [11:0] mic_in,
    input  logic        hold,
    output logic [10:0] num,
    output logic        num_valid,
    output logic [3:0]  level_idx
);

    localparam int            CW   = $clog2(WINDOW);
    localparam logic [CW-1:0] LAST = CW'(WINDOW - 1);

    peak_state_t   state;
    logic [CW-1:0] count;
    logic [10:0]   peak;
    logic [10:0]   mag;
    logic [10:0]   cand;
    logic [10:0]   held;
    logic          accept;
    logic          win_end;

    mic_abs_mag u_abs (
        .mic_in (mic_in),
        .mag    (mag)
    );

    assign accept  = sample_tick & ~hold;
    assign win_end = accept && (count == LAST);
    assign cand    = (mag > peak) ? mag : peak;

`ifdef MIC_PEAK_DECAY_EN
    localparam logic [10:0] DSTEP = 11'(DECAY_STEP);
    logic [10:0] decayed;
    assign decayed = (num > DSTEP) ? (num - DSTEP) : 11'd0;
    assign held    = (cand > decayed) ? cand : decayed;
`else
    assign held = cand;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ACCUM;
            count     <= '0;
            peak      <= '0;
            num       <= '0;
            num_valid <= 1'b0;
            level_idx <= '0;
        end else begin
            if (accept) begin
                if (win_end) begin
                    count <= '0;
                    peak  <= '0;
                end else begin
                    count <= count + CW'(1);
                    peak  <= cand;
                end
            end

            // PUBLISH always falls back to ACCUM; a window end is honoured in either state.
            unique case (state)
                ACCUM, PUBLISH: begin
                    if (win_end) begin
                        state     <= PUBLISH;
                        num_valid <= 1'b1;
                        num       <= held;
                        level_idx <= bar_count(held);
                    end else begin
                        state     <= ACCUM;
                        num_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ACCUM;
                    num_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mic_peak_level.sv
// Self-checking bench for mic_peak_level (WINDOW=4, DECAY_STEP=64) against a window-queue reference model.
module tb_mic_peak_level;

    localparam int WIN   = 4;
    localparam int DSTEP = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_tick = 1'b0;
    logic [11:0] mic_in = 12'd2048;
    logic        hold = 1'b0;
    logic [10:0] num;
    logic        num_valid;
    logic [3:0]  level_idx;

    int total  = 0;
    int passed = 0;

    int exp_num   = 0;
    int exp_valid = 0;
    int win_q[$];
    int thr[9] = '{205, 409, 614, 819, 1024, 1229, 1434, 1638, 1842};

    mic_peak_level #(.WINDOW(WIN), .DECAY_STEP(DSTEP)) dut (
        .clk         (clk),
        .reset       (reset),
        .sample_tick (sample_tick),
        .mic_in      (mic_in),
        .hold        (hold),
        .num         (num),
        .num_valid   (num_valid),
        .level_idx   (level_idx)
    );

    always #5 clk = ~clk;

    function automatic int ref_mag(input int v);
        int m;
        m = (v > 2048) ? v - 2048 : 2048 - v;
        return (m > 2047) ? 2047 : m;
    endfunction

    function automatic int ref_bars(input int lvl);
        int b = 0;
        foreach (thr[i]) if (thr[i] <= lvl) b++;
        return b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    endtask

    task automatic model_edge(input logic t, input logic h, input int v);
        int cand;
        int dec;
        exp_valid = 0;
        if (t && !h) begin
            win_q.push_back(ref_mag(v));
            if (win_q.size() == WIN) begin
                cand = 0;
                foreach (win_q[i]) if (win_q[i] > cand) cand = win_q[i];
`ifdef MIC_PEAK_DECAY_EN
                dec = (exp_num > DSTEP) ? exp_num - DSTEP : 0;
                if (dec > cand) cand = dec;
`else
                dec = 0;
`endif
                exp_num   = cand;
                exp_valid = 1;
                win_q.delete();
            end
        end
    endtask

    task automatic step(input logic t, input int v, input logic h);
        sample_tick = t;
        mic_in      = 12'(v);
        hold        = h;
        @(posedge clk);
        #1;
        model_edge(t, h, v);
        check("num", 32'(num), 32'(exp_num));
        check("num_valid", 32'(num_valid), 32'(exp_valid));
        check("level_idx", 32'(level_idx), 32'(ref_bars(exp_num)));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2048, 1'b0);
    endtask

    initial begin
        int v;
        logic t;
        logic h;

        #3;
        check("rst_num", 32'(num), 32'd0);
        check("rst_valid", 32'(num_valid), 32'd0);
        check("rst_idx", 32'(level_idx), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        idle(2);

        // Basic window: peak 500, 2 bars
        step(1, 2148, 0); step(1, 2048, 0); step(1, 1948, 0); step(1, 2548, 0);
        check("w1_num", 32'(num), 32'd500);
        check("w1_idx", 32'(level_idx), 32'd2);
        check("w1_valid", 32'(num_valid), 32'd1);
        idle(1);
        check("w1_valid_drop", 32'(num_valid), 32'd0);

        // Reset mid-window discards the partial peak
        step(1, 3000, 0); step(1, 3000, 0);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_num", 32'(num), 32'd0);
        check("mid_rst_idx", 32'(level_idx), 32'd0);
        check("mid_rst_valid", 32'(num_valid), 32'd0);
        exp_num = 0; exp_valid = 0; win_q.delete();
        #2 reset = 1'b0;
        idle(1);
        for (int i = 0; i < 4; i++) step(1, 2100, 0);
        check("post_rst_num", 32'(num), 32'd52);

        // Full-scale extremes, then a silent window
        step(1, 0, 0); step(1, 4095, 0); step(1, 2048, 0); step(1, 2048, 0);
        check("fs_num", 32'(num), 32'd2047);
        check("fs_idx", 32'(level_idx), 32'd9);
        for (int i = 0; i < 4; i++) step(1, 2048, 0);
`ifdef MIC_PEAK_DECAY_EN
        check("silent_num", 32'(num), 32'd1983);
`else
        check("silent_num", 32'(num), 32'd0);
`endif

        // Hold mid-window: held ticks ignored
        step(1, 2300, 0); step(1, 2048, 0);
        step(1, 4000, 1); step(1, 100, 1); step(1, 4095, 1);
        step(1, 2048, 0);
        check("hold_no_end", 32'(num_valid), 32'd0);
        step(1, 2100, 0);
        check("hold_end_valid", 32'(num_valid), 32'd1);
        check("hold_end_num_min", 32'(num >= 11'd252), 32'd1);

        // Back-to-back ticks for 8 cycles
        idle(1);
        for (int i = 0; i < 8; i++) step(1, 2048 + 100 * (i + 1), 0);
        check("b2b_valid", 32'(num_valid), 32'd1);
        check("b2b_num", 32'(num), 32'(exp_num));

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            t = ($urandom_range(0, 3) != 0);
            h = ($urandom_range(0, 4) == 0);
            case ($urandom_range(0, 5))
                0: v = 0;
                1: v = 4095;
                2: v = 2048;
                default: v = int'($urandom_range(0, 4095));
            endcase
            step(t, v, h);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
